// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              mem_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              error_o;

    // Arbiter side: consumes requests and memory responses.
    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output if_data_o, dm_rdata_o, mem_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, error_o
    );

    // Environment side: pipeline stages plus the memory itself.
    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  if_data_o, dm_rdata_o, mem_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, error_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data with unified stall
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort fires on the edge where the counter would step onto TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              i_done_q,    i_done_d;
    logic              d_done_q,    d_done_d;
    logic              error_q,     error_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q,   if_data_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              stall;

    assign stall = (bus.if_req_i & ~i_done_q) | (bus.dm_req_i & ~d_done_q);

    assign bus.mem_stall_o = stall;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.error_o     = error_q;

    // Next-state: arbitration (data first), ack/timeout handling, done-flag bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        error_d     = error_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;

        // Pipeline advances on this edge: completion marks belong to the old cycle.
        if (!stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.dm_req_i && !d_done_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we_i;
                    mem_addr_d  = bus.dm_addr_i;
                    mem_wdata_d = bus.dm_wdata_i;
                    cnt_d       = '0;
                    state_d     = D_BUSY;
                end else if (bus.if_req_i && !i_done_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr_i;
                    cnt_d       = '0;
                    state_d     = I_BUSY;
                end
            end
            D_BUSY: begin
                if (bus.mem_ack_i) begin
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata_i;
                    end
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_TRIP) begin
                    error_d   = 1'b1;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = '0;
                    end
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            I_BUSY: begin
                if (bus.mem_ack_i) begin
                    i_done_d  = 1'b1;
                    if_data_d = bus.mem_rdata_i;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_TRIP) begin
                    error_d   = 1'b1;
                    i_done_d  = 1'b1;
                    if_data_d = '0;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                mem_req_d = 1'b0;
                cnt_d     = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            error_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            error_q     <= error_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int T = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } txn_t;

    typedef struct {
        logic [31:0] if_exp;
        logic [31:0] dm_exp;
        logic        err_exp;
    } res_t;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        int          lat_d;
        int          lat_i;
    } op_t;

    txn_t txn_q[$];
    res_t res_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit resp_en  = 1'b0;

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] resp_mem  [logic [31:0]];
    logic [31:0] m_if = 32'h0;
    logic [31:0] m_dm = 32'h0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] resp_rd(input logic [31:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : mem_init(a);
    endfunction

    // Memory responder: acks each transaction after its planned latency, checks the bus fields.
    initial begin : responder
        txn_t cur;
        bit   rbusy;
        bit   have;
        int   n;
        rbusy = 1'b0;
        have  = 1'b0;
        n     = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                rbusy = 1'b0;
                continue;
            end
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o) begin
                if (!rbusy) begin
                    rbusy = 1'b1;
                    n = 1;
                    if (txn_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL txn_queue: got unexpected transaction addr %h expected none", bus.mem_addr_o);
                        have = 1'b0;
                    end else begin
                        cur  = txn_q.pop_front();
                        have = 1'b1;
                    end
                end else begin
                    n++;
                end
                if (have) begin
                    check("mem_addr", bus.mem_addr_o, cur.addr);
                    check("mem_we", {31'h0, bus.mem_we_o}, {31'h0, cur.we});
                    if (cur.we) check("mem_wdata", bus.mem_wdata_o, cur.wdata);
                    if (n == cur.lat) begin
                        bus.mem_ack_i = 1'b1;
                        if (cur.we) begin
                            resp_mem[cur.addr] = cur.wdata;
                            bus.mem_rdata_i = $urandom;
                        end else begin
                            bus.mem_rdata_i = resp_rd(cur.addr);
                        end
                    end
                end
            end else begin
                rbusy = 1'b0;
                have  = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = $urandom;
                end
            end
        end
    end

    // Monitor: whenever the pipeline advances, compare the visible results with the scoreboard.
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (resp_en && (bus.if_req_i || bus.dm_req_i) && !bus.mem_stall_o) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL res_queue: got pipeline advance expected none");
                end else begin
                    r = res_q.pop_front();
                    check("if_data", bus.if_data_o, r.if_exp);
                    check("dm_rdata", bus.dm_rdata_o, r.dm_exp);
                    check("error", {31'h0, bus.error_o}, {31'h0, r.err_exp});
                end
            end
        end
    end

    task automatic issue_op(input op_t o, input int gap);
        int   ld, li, exp_cyc, cyc;
        bit   to_d, to_i;
        txn_t t;
        res_t r;
        bit   done;
        to_d = (o.lat_d > T - 1);
        to_i = (o.lat_i > T - 1);
        ld   = to_d ? T - 1 : o.lat_d;
        li   = to_i ? T - 1 : o.lat_i;
        exp_cyc = 0;
        if (o.dm_req) begin
            t.we = o.dm_we; t.addr = o.dm_addr; t.wdata = o.dm_wdata; t.lat = o.lat_d;
            txn_q.push_back(t);
            if (o.dm_we) begin
                if (!to_d) model_mem[o.dm_addr] = o.dm_wdata;
            end else begin
                m_dm = to_d ? 32'h0 : model_rd(o.dm_addr);
            end
            m_err = m_err | to_d;
            exp_cyc = ld + 1;
        end
        if (o.if_req) begin
            t.we = 1'b0; t.addr = o.if_addr; t.wdata = 32'h0; t.lat = o.lat_i;
            txn_q.push_back(t);
            m_if  = to_i ? 32'h0 : model_rd(o.if_addr);
            m_err = m_err | to_i;
            exp_cyc = o.dm_req ? ld + li + 2 : li + 1;
        end
        r.if_exp = m_if; r.dm_exp = m_dm; r.err_exp = m_err;
        res_q.push_back(r);

        bus.if_req_i   = o.if_req;
        bus.if_addr_i  = o.if_addr;
        bus.dm_req_i   = o.dm_req;
        bus.dm_we_i    = o.dm_we;
        bus.dm_addr_i  = o.dm_addr;
        bus.dm_wdata_i = o.dm_wdata;

        cyc  = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.mem_stall_o) cyc++;
            else done = 1'b1;
        end
        check("stall_cycles", 32'(cyc), 32'(exp_cyc));
        @(posedge clk);
        #1;
        if (gap > 0) begin
            bus.if_req_i = 1'b0;
            bus.dm_req_i = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        n_checks++;
        $display("FAIL watchdog: got no completion expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        op_t dir[6];
        op_t o;
        bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0;
        bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;
        bus.dm_addr_i = 32'h0; bus.dm_wdata_i = 32'h0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0;
        model_mem[32'h40] = 32'h00A00093;
        resp_mem[32'h40]  = 32'h00A00093;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we_o}, 32'h0);
        check("rst_mem_addr", bus.mem_addr_o, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        check("rst_if_data", bus.if_data_o, 32'h0);
        check("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
        check("rst_error", {31'h0, bus.error_o}, 32'h0);
        check("rst_stall", {31'h0, bus.mem_stall_o}, 32'h0);

        // Reset in the middle of a fetch, then a late ack that must be ignored.
        @(posedge clk); #1;
        rst = 1'b0;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", {31'h0, bus.mem_req_o}, 32'h1);
        check("midrst_addr", bus.mem_addr_o, 32'h40);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_off", {31'h0, bus.mem_req_o}, 32'h0);
        check("midrst_stall", {31'h0, bus.mem_stall_o}, {31'h0, bus.if_req_i});
        check("midrst_error", {31'h0, bus.error_o}, 32'h0);
        rst = 1'b0;
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        check("late_ack_ignored", bus.if_data_o, 32'h0);
        check("refetch_started", {31'h0, bus.mem_req_o}, 32'h1);
        rst = 1'b1;
        bus.if_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resp_en = 1'b1;
        @(posedge clk); #1;

        // Directed cases: fetch, simultaneous, store, back-to-back, timeout, good after timeout.
        dir[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1, 3};
        dir[1] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        2, 4};
        dir[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3, 1};
        dir[3] = '{1'b1, 32'h48, 1'b0, 1'b0, 32'h0,   32'h0,        1, 1};
        dir[4] = '{1'b1, 32'h4C, 1'b0, 1'b0, 32'h0,   32'h0,        1, 9};
        dir[5] = '{1'b1, 32'h50, 1'b1, 1'b0, 32'h200, 32'h0,        5, 2};
        for (int i = 0; i < 6; i++) issue_op(dir[i], 0);

        for (int i = 0; i < 60; i++) begin
            o.if_req   = 1'($urandom_range(0, 1));
            o.dm_req   = 1'($urandom_range(0, 1));
            if (!o.if_req && !o.dm_req) o.dm_req = 1'b1;
            o.if_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            o.dm_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            o.dm_we    = 1'($urandom_range(0, 1));
            o.dm_wdata = $urandom;
            o.lat_d    = $urandom_range(1, 8);
            o.lat_i    = $urandom_range(1, 8);
            issue_op(o, $urandom_range(0, 2));
        end

        bus.if_req_i = 1'b0;
        bus.dm_req_i = 1'b0;
        repeat (4) @(posedge clk);
        n_checks++;
        if (txn_q.size() == 0 && res_q.size() == 0) n_pass++;
        else $display("FAIL queues_drained: got txn=%0d res=%0d expected 0", txn_q.size(), res_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
